// File: rtl/gate_unit_arbiter_if.sv
// Request/response bundle for gate_unit_arbiter.
// master: requesters + consumer side; slave: arbiter side.
interface gate_unit_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*2-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/gate_unit_arbiter.sv
// Shared registered AND/OR/XOR/NAND unit, NREQ requesters, RR grant.
// Ports: clock, reset_n (async low), bus (slave), busy. Macro GATE_ARB_FIXED_PRIO_EN.
module gate_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic clock,
  input  logic reset_n,
  gate_unit_arbiter_if.slave bus,
  output logic busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
`ifndef GATE_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   rr_ptr_q;
`endif

  logic             found;
  logic [IDW-1:0]   gnt;
  logic [NREQ-1:0]  gnt_oh;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0]       sel_op;
  int               base;
  int               idx;

  function automatic logic [WIDTH-1:0] gate_fn(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    unique case (op)
      2'b00:   gate_fn = a & b;
      2'b01:   gate_fn = a | b;
      2'b10:   gate_fn = a ^ b;
      default: gate_fn = ~(a & b);
    endcase
  endfunction

  // Scan NREQ slots starting at base, wrapping; first valid wins.
  always_comb begin
    found  = 1'b0;
    gnt    = '0;
    gnt_oh = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    idx    = 0;
`ifdef GATE_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = int'(rr_ptr_q);
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = (base + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found       = 1'b1;
        gnt         = IDW'(idx);
        gnt_oh[idx] = 1'b1;
        sel_a       = bus.req_a[idx*WIDTH +: WIDTH];
        sel_b       = bus.req_b[idx*WIDTH +: WIDTH];
        sel_op      = bus.req_op[idx*2 +: 2];
      end
    end
  end

  // Gated by reset_n so nothing is accepted while held in reset.
  assign bus.req_ready = (reset_n && state_q == IDLE && found)
                         ? gnt_oh : '0;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
`ifndef GATE_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            op_q     <= sel_op;
            id_q     <= gnt;
`ifndef GATE_ARB_FIXED_PRIO_EN
            rr_ptr_q <= IDW'((int'(gnt) + 1) % NREQ);
`endif
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          data_q  <= gate_fn(op_q, a_q, b_q);
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter.
// Directed steps plus random transactions against a grant/result model.
module tb_gate_unit_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic busy;

  gate_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  gate_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [1:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Pick the first requesting index at or after the pointer, wrapping.
  function automatic int ref_grant(input logic [3:0] m, input int p);
    int start;
`ifdef GATE_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int k = 0; k < NREQ; k++)
      if (m[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_txn(input logic [3:0] mask, input logic [63:0] a,
                         input logic [63:0] b, input logic [7:0] op,
                         input int stall, output int g,
                         output logic [15:0] d);
    logic [15:0] exp;
    logic [3:0]  oh;
    bus.req_valid = mask;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.rsp_ready = 1'b0;
    #1;
    g   = ref_grant(mask, ptr);
    exp = ref_op(op[g*2 +: 2], a[g*16 +: 16], b[g*16 +: 16]);
    oh  = '0;
    oh[g] = 1'b1;
    chk("ready_idle", bus.req_ready, oh);
    chk("busy_idle", busy, 1'b0);
    chk("valid_idle", bus.rsp_valid, 1'b0);
    step();
    bus.req_a  = {$urandom, $urandom};
    bus.req_b  = {$urandom, $urandom};
    bus.req_op = 8'($urandom);
    chk("ready_exec", bus.req_ready, 4'h0);
    chk("busy_exec", busy, 1'b1);
    chk("valid_exec", bus.rsp_valid, 1'b0);
    step();
    chk("valid_resp", bus.rsp_valid, 1'b1);
    chk("id_resp", bus.rsp_id, g);
    chk("data_resp", bus.rsp_data, exp);
    d = bus.rsp_data;
    for (int s = 0; s < stall; s++) begin
      step();
      chk("valid_hold", bus.rsp_valid, 1'b1);
      chk("id_hold", bus.rsp_id, g);
      chk("data_hold", bus.rsp_data, exp);
      chk("ready_hold", bus.req_ready, 4'h0);
      chk("busy_hold", busy, 1'b1);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("valid_done", bus.rsp_valid, 1'b0);
    chk("busy_done", busy, 1'b0);
    bus.rsp_ready = 1'b0;
    ptr = (g + 1) % NREQ;
  endtask

  task automatic idle_cycle();
    bus.req_valid = '0;
    #1;
    chk("ready_none", bus.req_ready, 4'h0);
    step();
    chk("busy_none", busy, 1'b0);
    chk("valid_none", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    int g;
    int exp_g;
    logic [15:0] d;

    // Reset with all requesters asking.
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    reset_n       = 1'b0;
    repeat (3) step();
    chk("rst_ready", bus.req_ready, 4'h0);
    chk("rst_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_id", bus.rsp_id, 2'd0);
    chk("rst_data", bus.rsp_data, 16'h0000);
    bus.req_valid = '0;
    reset_n = 1'b1;
    step();
    ptr = 0;

    // Fairness with everyone requesting.
    for (int i = 0; i < 5; i++) begin
      run_txn(4'hF, {$urandom, $urandom}, {$urandom, $urandom},
              8'($urandom), 0, g, d);
`ifdef GATE_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % NREQ;
`endif
      chk("fair_order", g, exp_g);
    end

    // Single AND from requester 0.
    run_txn(4'h1, 64'hF0F0, 64'hFF00, 8'h00, 0, g, d);
    chk("and_id", g, 0);
    chk("and_data", d, 16'hF000);

    // Opcodes on requester 0.
    run_txn(4'h1, 64'hAAAA, 64'h5555, 8'h01, 0, g, d);
    chk("or_data", d, 16'hFFFF);
    run_txn(4'h1, 64'hAAAA, 64'h5555, 8'h02, 0, g, d);
    chk("xor_data", d, 16'hFFFF);
    run_txn(4'h1, 64'hAAAA, 64'h5555, 8'h03, 0, g, d);
    chk("nand_data", d, 16'hFFFF);
    run_txn(4'h1, 64'h00FF, 64'h00FF, 8'h02, 0, g, d);
    chk("xor_zero", d, 16'h0000);

    // Backpressure for 5 cycles with requests held.
    run_txn(4'hF, {$urandom, $urandom}, {$urandom, $urandom},
            8'($urandom), 5, g, d);

    idle_cycle();

    // Reset during EXEC drops the op.
    bus.req_valid = 4'h3;
    bus.req_op    = 8'h00;
    step();
    chk("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_ready", bus.req_ready, 4'h0);
    bus.req_valid = '0;
    repeat (2) step();
    reset_n = 1'b1;
    ptr = 0;
    step();
    chk("post_rst_valid", bus.rsp_valid, 1'b0);
    step();
    chk("post_rst_valid2", bus.rsp_valid, 1'b0);
    run_txn(4'hC, {$urandom, $urandom}, {$urandom, $urandom},
            8'($urandom), 0, g, d);
    chk("post_rst_grant", g, 2);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      run_txn(4'($urandom_range(1, 15)),
              {$urandom, $urandom}, {$urandom, $urandom},
              8'($urandom), int'($urandom_range(0, 3)), g, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
